// File: rtl/fc_pkg.sv
// Shared definitions for the FC tile controller: state encodings and tiling helpers.
package fc_pkg;

  typedef logic [2:0] fc_state_t;

  localparam fc_state_t ST_IDLE    = 3'd0;
  localparam fc_state_t ST_LOAD    = 3'd1;
  localparam fc_state_t ST_COMPUTE = 3'd2;
  localparam fc_state_t ST_FLUSH   = 3'd3;
  localparam fc_state_t ST_OUT     = 3'd4;
  localparam fc_state_t ST_DONE    = 3'd5;

  function automatic int num_tiles(input int num_out, input int tile);
    return num_out / tile;
  endfunction

  // Output neurons must split into whole tiles.
  function automatic bit tiling_ok(input int num_out, input int tile);
    return (tile > 0) && ((num_out % tile) == 0);
  endfunction

endpackage

// File: rtl/fc_tile_ctrl_if.sv
// Control/status bundle between the FC tile controller and the DMA, weight fetch,
// IFM buffer and PE array.
interface fc_tile_ctrl_if
  import fc_pkg::*;
#(
  parameter int AW = 14,
  parameter int TW = 10
);
  logic          start;
  logic          abort;
  logic          valid_ifm;
  logic          ifm_ready;
  logic          ifm_wr_en;
  logic [AW-1:0] ifm_wr_addr;
  logic          wgt_valid;
  logic          wgt_rd_en;
  logic          ifm_rd_en;
  logic [AW-1:0] ifm_rd_addr;
  logic          acc_clr;
  logic          set_output;
  logic [TW-1:0] tile_idx;
  logic          busy;
  logic          done;
  fc_state_t     state;

  modport master (
    input  start, abort, valid_ifm, wgt_valid,
    output ifm_ready, ifm_wr_en, ifm_wr_addr, wgt_rd_en, ifm_rd_en, ifm_rd_addr,
           acc_clr, set_output, tile_idx, busy, done, state
  );

  modport slave (
    output start, abort, valid_ifm, wgt_valid,
    input  ifm_ready, ifm_wr_en, ifm_wr_addr, wgt_rd_en, ifm_rd_en, ifm_rd_addr,
           acc_clr, set_output, tile_idx, busy, done, state
  );
endinterface

// File: rtl/fc_addr_cnt.sv
// Up-counter with enable, synchronous clear and a terminal-count flag; wraps to 0
// when enabled at the terminal count.
module fc_addr_cnt #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_reg, cnt_next;

  assign tc  = (cnt_reg == W'(MAX));
  assign cnt = cnt_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (en)
      cnt_next = tc ? '0 : cnt_reg + W'(1);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end
endmodule

// File: rtl/fc_tile_ctrl.sv
// FC layer controller: loads the IFM once, replays it per output tile against the
// weight stream, drains the PE pipeline and strobes each tile result.
module fc_tile_ctrl
  import fc_pkg::*;
#(
  parameter int IFM_SIZE = 9216,
  parameter int TILE     = 8,
  parameter int NUM_OUT  = 4096,
  parameter int PE_LAT   = 2,
  parameter int AW       = $clog2(IFM_SIZE),
  parameter int TW       = $clog2(NUM_OUT / TILE) + 1
) (
  input  logic           clk1,
  input  logic           rst_n,
  fc_tile_ctrl_if.master bus
);
  localparam int NT = num_tiles(NUM_OUT, TILE);
  localparam int FW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  generate
    if (!tiling_ok(NUM_OUT, TILE) || IFM_SIZE < 2 || PE_LAT < 1) begin : g_bad_cfg
      $error("fc_tile_ctrl: invalid parameter set");
    end
  endgenerate

  fc_state_t     state_reg, state_next;
  logic [TW-1:0] tile_idx_reg, tile_idx_next;
  logic [AW-1:0] load_cnt, rd_cnt;
  logic [FW-1:0] unused_flush_cnt;
  logic          load_tc, rd_tc, flush_tc;
  logic          in_idle, in_load, in_comp, in_flush, in_out, in_done;
  logic          load_acc, rd_acc, tile_last, cnt_clr;

  assign in_idle   = (state_reg == ST_IDLE);
  assign in_load   = (state_reg == ST_LOAD);
  assign in_comp   = (state_reg == ST_COMPUTE);
  assign in_flush  = (state_reg == ST_FLUSH);
  assign in_out    = (state_reg == ST_OUT);
  assign in_done   = (state_reg == ST_DONE);
  assign load_acc  = in_load & bus.valid_ifm;
  assign rd_acc    = in_comp & bus.wgt_valid;
  assign tile_last = (tile_idx_reg == TW'(NT - 1));
  assign cnt_clr   = bus.abort | in_idle;

  fc_addr_cnt #(.W(AW), .MAX(IFM_SIZE - 1)) u_load_cnt (
    .clk1(clk1), .rst_n(rst_n), .clr(cnt_clr), .en(load_acc),
    .cnt(load_cnt), .tc(load_tc)
  );

  fc_addr_cnt #(.W(AW), .MAX(IFM_SIZE - 1)) u_rd_cnt (
    .clk1(clk1), .rst_n(rst_n), .clr(cnt_clr), .en(rd_acc),
    .cnt(rd_cnt), .tc(rd_tc)
  );

  // Flush counter restarts from 0 every time FLUSH is entered.
  fc_addr_cnt #(.W(FW), .MAX(PE_LAT - 1)) u_flush_cnt (
    .clk1(clk1), .rst_n(rst_n), .clr(bus.abort | ~in_flush), .en(in_flush),
    .cnt(unused_flush_cnt), .tc(flush_tc)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (bus.start) state_next = ST_LOAD;
      ST_LOAD:    if (load_acc && load_tc) state_next = ST_COMPUTE;
      ST_COMPUTE: if (rd_acc && rd_tc) state_next = ST_FLUSH;
      ST_FLUSH:   if (flush_tc) state_next = ST_OUT;
      ST_OUT:     state_next = tile_last ? ST_DONE : ST_COMPUTE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (bus.abort)
      state_next = ST_IDLE;
  end

  always_comb begin
    tile_idx_next = tile_idx_reg;
    if (cnt_clr)
      tile_idx_next = '0;
    else if (in_out && !tile_last)
      tile_idx_next = tile_idx_reg + TW'(1);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      tile_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      tile_idx_reg <= tile_idx_next;
    end
  end

  assign bus.ifm_ready   = in_load;
  assign bus.ifm_wr_en   = load_acc;
  assign bus.ifm_wr_addr = load_cnt;
  assign bus.wgt_rd_en   = rd_acc;
  assign bus.ifm_rd_en   = rd_acc;
  assign bus.ifm_rd_addr = rd_cnt;
  // Accumulators clear only on entry into COMPUTE, never while replaying.
  assign bus.acc_clr     = (state_next == ST_COMPUTE) & ~in_comp;
  assign bus.set_output  = in_out;
  assign bus.tile_idx    = tile_idx_reg;
  assign bus.busy        = ~in_idle;
  assign bus.done        = in_done;
  assign bus.state       = state_reg;
endmodule
